// File: rtl/rv_muldiv.sv
// rv_muldiv: iterative RV32M-style multiply/divide unit.
// One result bit is retired per cycle; divide-by-zero and signed overflow
// resolve in a single cycle without entering BUSY.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a request, req_ready high unless flush/rst
// BUSY  | shift-add multiply or restoring divide, XLEN iterations
// DONE  | result held on resp_data/resp_tag until resp_ready
module rv_muldiv #(
    parameter int XLEN = 32,
    parameter int TAGW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic [TAGW-1:0] req_tag,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic [TAGW-1:0] resp_tag
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_REM    = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic            neg_q, neg_d;
    logic [XLEN-1:0] opnd_q, opnd_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] resp_data_q, resp_data_d;
    logic [TAGW-1:0] resp_tag_q, resp_tag_d;

    logic            accept;
    logic            is_div, is_rem, a_signed, b_signed, a_neg, b_neg;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] mag_a, mag_b, special_res;

    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   mul_hi_n, mul_lo_n;
    logic [XLEN:0]     div_shift, div_diff;
    logic              div_ge;
    logic [XLEN-1:0]   div_hi_n, div_lo_n;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   final_res;

    assign req_ready  = (state_q == S_IDLE) && !flush && !rst;
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state_q == S_DONE);
    assign resp_data  = resp_data_q;
    assign resp_tag   = resp_tag_q;

    // Request decode: operand signedness, magnitudes and single-cycle special cases.
    always_comb begin
        is_div   = req_op[2];
        is_rem   = req_op[2] && req_op[1];
        a_signed = (req_op == OP_MULH) || (req_op == OP_MULHSU) ||
                   (req_op == OP_DIV)  || (req_op == OP_REM);
        b_signed = (req_op == OP_MULH) || (req_op == OP_DIV) || (req_op == OP_REM);
        a_neg    = a_signed && req_a[XLEN-1];
        b_neg    = b_signed && req_b[XLEN-1];
        mag_a    = a_neg ? -req_a : req_a;
        mag_b    = b_neg ? -req_b : req_b;
        div_zero = is_div && (req_b == '0);
        div_ovf  = ((req_op == OP_DIV) || (req_op == OP_REM)) &&
                   (req_a == MIN_NEG) && (req_b == '1);
        if (div_zero) begin
            special_res = is_rem ? req_a : '1;
        end else begin
            special_res = is_rem ? '0 : req_a;
        end
    end

    // One iteration of shift-add multiply and restoring divide, plus final sign fix-up.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : '0)};
        mul_hi_n  = mul_sum[XLEN:1];
        mul_lo_n  = {mul_sum[0], lo_q[XLEN-1:1]};

        div_shift = {hi_q, lo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_ge    = !div_diff[XLEN];
        div_hi_n  = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
        div_lo_n  = {lo_q[XLEN-2:0], div_ge};

        prod      = {mul_hi_n, mul_lo_n};
        prod_s    = neg_q ? -prod : prod;

        final_res = '0;
        case (op_q)
            3'd0:          final_res = prod_s[XLEN-1:0];
            3'd1, 3'd2, 3'd3: final_res = prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5:    final_res = neg_q ? -div_lo_n : div_lo_n;
            default:       final_res = neg_q ? -div_hi_n : div_hi_n;
        endcase
    end

    // Next-state and datapath register updates; flush overrides everything.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        neg_d       = neg_q;
        opnd_d      = opnd_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        resp_data_d = resp_data_q;
        resp_tag_d  = resp_tag_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d       = req_op;
                    resp_tag_d = req_tag;
                    neg_d      = is_rem ? a_neg : (a_neg ^ b_neg);
                    cnt_d      = CNT_LAST;
                    hi_d       = '0;
                    // Divide iterates over the dividend with the divisor held;
                    // multiply shifts the multiplier and adds the multiplicand.
                    opnd_d     = is_div ? mag_b : mag_a;
                    lo_d       = is_div ? mag_a : mag_b;
                    if (div_zero || div_ovf) begin
                        resp_data_d = special_res;
                        state_d     = S_DONE;
                    end else begin
                        state_d     = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                hi_d  = op_q[2] ? div_hi_n : mul_hi_n;
                lo_d  = op_q[2] ? div_lo_n : mul_lo_n;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    cnt_d       = '0;
                    resp_data_d = final_res;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (flush) begin
            state_d = S_IDLE;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            neg_q       <= 1'b0;
            opnd_q      <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            resp_data_q <= '0;
            resp_tag_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            neg_q       <= neg_d;
            opnd_q      <= opnd_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            resp_data_q <= resp_data_d;
            resp_tag_q  <= resp_tag_d;
        end
    end

endmodule

// File: doc/rv_muldiv.md
RV_MULDIV -- requirements
Module: rv_muldiv

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand and result width in bits (legal values 8..64, even).
REQ-002 The block SHALL have parameter TAGW, default 5, giving the width of the destination-register tag carried through with each operation.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 flush  input  1  abandons any in-flight operation.
REQ-007 req_valid  input  1  a request is present.
REQ-008 req_ready  output  1  the block can accept a request.
REQ-009 req_op  input  3  operation code, RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-010 req_a  input  XLEN  rs1 operand (multiplicand or dividend).
REQ-011 req_b  input  XLEN  rs2 operand (multiplier or divisor).
REQ-012 req_tag  input  TAGW  destination tag, passed through unmodified.
REQ-013 resp_valid  output  1  a result is available.
REQ-014 resp_ready  input  1  the consumer accepts the result.
REQ-015 resp_data  output  XLEN  result.
REQ-016 resp_tag  output  TAGW  tag captured with the request.

Function
REQ-017 The block SHALL implement three states: IDLE, BUSY and DONE.
REQ-018 req_ready SHALL be 1 only when state==IDLE, flush==0 and rst==0.
REQ-019 A request SHALL be accepted on the edge where req_valid && req_ready; the accepting cycle is T.
REQ-020 On acceptance, the block SHALL register the op, the tag, the operand magnitudes and the result-sign flags.
- Signed treatment: MULH treats both operands as signed; MULHSU treats a as signed and b as unsigned; DIV and REM treat both as signed.
- All other operations treat both operands as unsigned.
REQ-021 Normal operations SHALL move IDLE->BUSY at T+1, retire one bit per cycle for exactly XLEN cycles, then enter DONE; resp_valid SHALL first be 1 in cycle T+XLEN+1.
REQ-022 Multiply SHALL form the unsigned 2*XLEN product of the magnitudes, then take the two's complement if the result sign is negative.
- MUL returns the low XLEN bits.
- MULH, MULHSU and MULHU return the high XLEN bits.
REQ-023 Divide SHALL use a restoring magnitude algorithm.
- The quotient is negated when the operand signs differ (DIV only).
- The remainder takes the sign of the dividend (REM only).
REQ-024 Divisor==0 SHALL bypass BUSY and enter DONE at T+1.
- DIV and DIVU return all ones.
- REM and REMU return req_a.
REQ-025 Signed overflow (DIV/REM, a==most-negative, b==all ones) SHALL bypass BUSY and enter DONE at T+1.
- DIV returns a.
- REM returns 0.
REQ-026 In DONE, resp_valid SHALL be 1 and resp_data/resp_tag SHALL hold stable until resp_valid && resp_ready; the block SHALL then return to IDLE on the next edge.
REQ-027 No new request SHALL be accepted in the cycle its response is consumed; the earliest next acceptance is the following cycle.
REQ-028 flush==1 in any state SHALL force IDLE on the next edge, drop resp_valid and emit no response for the killed operation; flush has priority over req_valid and resp_ready.
REQ-029 resp_valid SHALL never be 1 in IDLE or BUSY.
REQ-030 All arithmetic SHALL be modulo 2^XLEN (2^(2*XLEN) for the product); no exceptions or flags.

Reset
REQ-031 While rst==1, on each edge: state<=IDLE, resp_valid<=0, resp_data<=0, resp_tag<=0, internal counters and accumulators<=0.
REQ-032 req_ready SHALL be 0 during the reset cycle and 1 the cycle after rst deasserts (flush==0).
REQ-033 Reset asserted in BUSY or DONE SHALL discard the operation; no response SHALL appear afterward.

Verification
REQ-034 Multiply (XLEN=32), each checked for resp_valid exactly at T+33:
- MUL 7, 0xFFFFFFFD -> 0xFFFFFFEB
- MULH 0x80000000, 0x80000000 -> 0x40000000
- MULHSU 0xFFFFFFFF, 0xFFFFFFFF -> 0xFFFFFFFF
- MULHU 0xFFFFFFFF, 0xFFFFFFFF -> 0xFFFFFFFE
REQ-035 Signed and unsigned divide:
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD
- REM 0xFFFFFFF9 / 2 -> 0xFFFFFFFF
- DIVU 100 / 7 -> 14
- REMU 100 / 7 -> 2
- all at T+33, tag 0x1A returned on resp_tag
REQ-036 Special cases, each with resp_valid at T+1:
- DIVU 0x1234 / 0 -> 0xFFFFFFFF
- REM 0x1234 / 0 -> 0x1234
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000
- REM 0x80000000 / 0xFFFFFFFF -> 0
REQ-037 Backpressure: hold resp_ready=0 for 5 cycles after resp_valid -> resp_data/resp_tag stable and req_ready=0 throughout; pulse resp_ready -> IDLE next cycle, req_ready=1.
REQ-038 Flush and reset:
- flush at T+10 of a DIV -> no resp_valid ever for it, req_ready=1 at T+11.
- rst at T+20 -> all outputs 0, req_ready=1 the cycle after rst falls.
- flush with req_valid in IDLE -> no acceptance.
